// File: rtl/pru_pkg.sv
// pru_pkg: shared packet head field positions and ingress arbiter FSM encodings.
package pru_pkg;

  // Head beat field positions (head layout assumes a 128-bit beat)
  localparam int PKT_TYPE_MSB  = 127;
  localparam int PKT_TYPE_LSB  = 122;
  localparam int PKT_SIZE_MSB  = 121;
  localparam int PKT_SIZE_LSB  = 114;
  localparam int SRC_ADDR_MSB  = 63;
  localparam int SRC_ADDR_LSB  = 32;
  localparam int TRGT_ADDR_MSB = 31;
  localparam int TRGT_ADDR_LSB = 0;

  // Arbiter FSM states, kept as plain constants so older tools can share them
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HEAD = 2'd1;
  localparam logic [1:0] BODY = 2'd2;

  // Number of data beats that follow a head beat
  function automatic logic [7:0] pktSize(input logic [127:0] head);
    return head[PKT_SIZE_MSB:PKT_SIZE_LSB];
  endfunction

endpackage

// File: rtl/pru_rr_pick.sv
// pru_rr_pick: round-robin winner search. Starting at iPtr, scans the request
// vector upward with wrap-around and returns the first set position one-hot
// and as an index. oOneHot is all-zero when nothing is requesting.
module pru_rr_pick #(
  parameter int NP = 17,
  parameter int SW = 5
) (
  input  logic [NP-1:0] iReq,
  input  logic [SW-1:0] iPtr,
  output logic [NP-1:0] oOneHot,
  output logic [SW-1:0] oIdx
);

  logic [SW:0] w_cand;
  logic        w_found;

  // Walk NP candidates beginning at the pointer; the first requester seen wins
  always_comb begin
    oOneHot = '0;
    oIdx    = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NP; k++) begin
      w_cand = {1'b0, iPtr} + (SW+1)'(k);
      if (w_cand >= (SW+1)'(NP)) begin
        w_cand = w_cand - (SW+1)'(NP);
      end
      if (!w_found && iReq[w_cand[SW-1:0]]) begin
        w_found                   = 1'b1;
        oOneHot[w_cand[SW-1:0]]   = 1'b1;
        oIdx                      = w_cand[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/pru_ingress_arbiter.sv
// pru_ingress_arbiter: shares the ingress datapath among the port interfaces.
// One requester is granted per packet and keeps the grant from head beat to
// EOP; accepted beats are forwarded through a single registered output stage
// tagged with source index, SOP and EOP. The server port (index NP-1) can be
// given absolute priority over the round-robin search at each arbitration.
module pru_ingress_arbiter
  import pru_pkg::*;
#(
  parameter int PW       = 128,
  parameter int NP       = 17,
  parameter int SW       = 5,
  parameter int SRV_PRIO = 1
) (
  input  logic             iClk,
  input  logic             iRstn,
  input  logic [NP-1:0]    iReq_vld,
  input  logic [NP*PW-1:0] iReq_pkt,
  output logic [NP-1:0]    oReq_ack,
  output logic             oArb_vld,
  output logic [PW-1:0]    oArb_pkt,
  output logic [SW-1:0]    oArb_src,
  output logic             oArb_sop,
  output logic             oArb_eop,
  input  logic             iArb_ack,
  output logic             oBusy
);

  localparam logic [SW-1:0] SRV_IDX = SW'(NP-1);

  logic [1:0]    r_state;
  logic [SW-1:0] r_grant;
  logic [SW-1:0] r_rrPtr;
  logic [7:0]    r_rem;

  logic [PW-1:0] w_pkt;
  logic          w_grantVld;
  logic          w_slotFree;
  logic          w_xfer;
  logic          w_eop;
  logic [7:0]    w_size;
  logic [NP-1:0] w_pickOneHot;
  logic [SW-1:0] w_pickIdx;
  logic          w_pickAny;
  logic [SW-1:0] w_winner;
  logic [SW-1:0] w_nextPtr;
  logic          w_srvOwns;

  pru_rr_pick #(
    .NP (NP),
    .SW (SW)
  ) u_rrPick (
    .iReq    (iReq_vld),
    .iPtr    (r_rrPtr),
    .oOneHot (w_pickOneHot),
    .oIdx    (w_pickIdx)
  );

  assign w_pickAny  = |w_pickOneHot;
  assign w_winner   = ((SRV_PRIO != 0) && iReq_vld[NP-1]) ? SRV_IDX : w_pickIdx;
  assign w_slotFree = !oArb_vld || iArb_ack;
  assign w_xfer     = (r_state != IDLE) && w_slotFree && w_grantVld;
  assign w_size     = pktSize(w_pkt);
  assign w_eop      = (r_state == HEAD) ? (w_size == 8'd0) : (r_rem == 8'd1);
  assign w_srvOwns  = (SRV_PRIO != 0) && (r_grant == SRV_IDX);
  assign w_nextPtr  = (r_grant == SRV_IDX) ? '0 : r_grant + 1'b1;
  assign oBusy      = (r_state != IDLE);

  // Select the beat and valid of the current grant holder
  always_comb begin
    w_pkt      = '0;
    w_grantVld = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (r_grant == SW'(i)) begin
        w_pkt      = iReq_pkt[i*PW +: PW];
        w_grantVld = iReq_vld[i];
      end
    end
  end

  // Only the grant holder is acked, and only while the output slot can take a beat
  always_comb begin
    oReq_ack = '0;
    for (int i = 0; i < NP; i++) begin
      if ((r_state != IDLE) && w_slotFree && (r_grant == SW'(i))) begin
        oReq_ack[i] = 1'b1;
      end
    end
  end

  // Packet FSM: arbitrate in IDLE, take the size from the head, count down the body
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pickAny) begin
            r_grant <= w_winner;
            r_state <= HEAD;
          end
        end
        HEAD: begin
          if (w_xfer) begin
            r_rem   <= w_size;
            r_state <= (w_size == 8'd0) ? IDLE : BODY;
          end
        end
        BODY: begin
          if (w_xfer) begin
            r_rem <= r_rem - 8'd1;
            if (r_rem == 8'd1) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Advance the round-robin pointer past the owner at EOP; a prioritised server leaves it alone
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_rrPtr <= '0;
    end else if (w_xfer && w_eop && !w_srvOwns) begin
      r_rrPtr <= w_nextPtr;
    end
  end

  // Output stage: load on an accepted beat, empty when drained with nothing new arriving
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      oArb_vld <= 1'b0;
      oArb_pkt <= '0;
      oArb_src <= '0;
      oArb_sop <= 1'b0;
      oArb_eop <= 1'b0;
    end else if (w_xfer) begin
      oArb_vld <= 1'b1;
      oArb_pkt <= w_pkt;
      oArb_src <= r_grant;
      oArb_sop <= (r_state == HEAD);
      oArb_eop <= w_eop;
    end else if (iArb_ack) begin
      oArb_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pru_ingress_arbiter.sv
// tb_pru_ingress_arbiter: directed scenarios plus randomized traffic for the
// ingress arbiter, checked every cycle against a packet-level reference model.
module tb_pru_ingress_arbiter;

  localparam int PW       = 128;
  localparam int NP       = 17;
  localparam int SW       = 5;
  localparam int SRV_PRIO = 1;

  logic             iClk;
  logic             iRstn;
  logic [NP-1:0]    iReq_vld;
  logic [NP*PW-1:0] iReq_pkt;
  logic [NP-1:0]    oReq_ack;
  logic             oArb_vld;
  logic [PW-1:0]    oArb_pkt;
  logic [SW-1:0]    oArb_src;
  logic             oArb_sop;
  logic             oArb_eop;
  logic             iArb_ack;
  logic             oBusy;

  int total;
  int bad;

  // Requester-side state
  logic [NP-1:0] curVld;
  logic [PW-1:0] curBeat [NP];
  int            bodyLeft [NP];
  int            pendSize [NP][8];
  int            pendCnt [NP];
  int            pendRd [NP];
  bit            bubbleEn;
  int            ackMode;
  int            beatsSent;
  int            beatsOut;
  int            beatsQueued;
  int            cycleNo;
  int            srcLog[$];
  int            cycLog[$];

  // Reference model state
  int            mOwner;
  int            mLeft;
  int            mPtr;
  bit            mHeadNext;
  bit            eVld;
  bit            eSop;
  bit            eEop;
  int            eSrc;
  logic [PW-1:0] ePkt;
  logic [NP-1:0] expAck;
  logic [NP-1:0] ackSeen;
  bit            outDrain;

  int exp3 [6] = '{2, 5, 9, 2, 5, 9};
  int exp4 [3] = '{16, 6, 0};

  pru_ingress_arbiter #(
    .PW       (PW),
    .NP       (NP),
    .SW       (SW),
    .SRV_PRIO (SRV_PRIO)
  ) dut (
    .iClk     (iClk),
    .iRstn    (iRstn),
    .iReq_vld (iReq_vld),
    .iReq_pkt (iReq_pkt),
    .oReq_ack (oReq_ack),
    .oArb_vld (oArb_vld),
    .oArb_pkt (oArb_pkt),
    .oArb_src (oArb_src),
    .oArb_sop (oArb_sop),
    .oArb_eop (oArb_eop),
    .iArb_ack (iArb_ack),
    .oBusy    (oBusy)
  );

  // Free-running 10-unit clock
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] randBeat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic queuePkt(input int port, input int size);
    if (pendCnt[port] < 8) begin
      pendSize[port][pendCnt[port]] = size;
      pendCnt[port]++;
      beatsQueued += size + 1;
    end
  endtask

  task automatic clearRequesters();
    curVld = '0;
    for (int p = 0; p < NP; p++) begin
      curBeat[p]  = '0;
      bodyLeft[p] = 0;
      pendCnt[p]  = 0;
      pendRd[p]   = 0;
    end
    beatsSent   = 0;
    beatsOut    = 0;
    beatsQueued = 0;
  endtask

  task automatic drivePins();
    iReq_vld = curVld;
    for (int p = 0; p < NP; p++) begin
      iReq_pkt[p*PW +: PW] = curBeat[p];
    end
  endtask

  // Requesters retire acked beats, then present the next body beat or a new head
  task automatic applyStimulus(input logic [NP-1:0] acked);
    logic [PW-1:0] h;
    for (int p = 0; p < NP; p++) begin
      if (curVld[p] && acked[p]) begin
        curVld[p] = 1'b0;
        beatsSent++;
      end
      if (!curVld[p] && !(bubbleEn && ($urandom_range(0, 3) == 0))) begin
        if (bodyLeft[p] > 0) begin
          curBeat[p] = randBeat();
          bodyLeft[p]--;
          curVld[p] = 1'b1;
        end else if (pendRd[p] < pendCnt[p]) begin
          h = randBeat();
          h[121:114] = 8'(pendSize[p][pendRd[p]]);
          bodyLeft[p] = pendSize[p][pendRd[p]];
          pendRd[p]++;
          curBeat[p] = h;
          curVld[p]  = 1'b1;
        end
      end
    end
    if (ackMode == 0) iArb_ack = 1'b1;
    else if (ackMode == 1) iArb_ack = ($urandom_range(0, 99) < 70);
    drivePins();
  endtask

  task automatic modelReset();
    mOwner    = -1;
    mLeft     = 0;
    mPtr      = 0;
    mHeadNext = 1'b0;
    eVld      = 1'b0;
    eSop      = 1'b0;
    eEop      = 1'b0;
    eSrc      = 0;
    ePkt      = '0;
  endtask

  task automatic modelAck();
    expAck = '0;
    if (mOwner >= 0 && (!eVld || iArb_ack)) expAck[mOwner] = 1'b1;
  endtask

  // One clock of the packet-level model: arbitrate when free, otherwise move the owner's beat
  task automatic modelClock();
    logic [PW-1:0] beat;
    int            w;
    int            idx;
    if (mOwner < 0) begin
      if (eVld && iArb_ack) eVld = 1'b0;
      if (iReq_vld != '0) begin
        w = -1;
        if (SRV_PRIO != 0 && iReq_vld[NP-1]) w = NP - 1;
        else begin
          for (int k = 0; k < NP; k++) begin
            idx = (mPtr + k) % NP;
            if (w < 0 && iReq_vld[idx]) w = idx;
          end
        end
        mOwner    = w;
        mHeadNext = 1'b1;
      end
    end else if ((!eVld || iArb_ack) && iReq_vld[mOwner]) begin
      beat = iReq_pkt[mOwner*PW +: PW];
      eVld = 1'b1;
      ePkt = beat;
      eSrc = mOwner;
      eSop = mHeadNext;
      if (mHeadNext) mLeft = int'(beat[121:114]);
      else mLeft = mLeft - 1;
      mHeadNext = 1'b0;
      eEop = (mLeft == 0);
      if (eEop) begin
        if (!(SRV_PRIO != 0 && mOwner == NP - 1)) mPtr = (mOwner + 1) % NP;
        mOwner = -1;
      end
    end else if (eVld && iArb_ack) begin
      eVld = 1'b0;
    end
  endtask

  task automatic checkOutput();
    checkVal("arb_vld", 128'(oArb_vld), 128'(eVld));
    checkVal("busy", 128'(oBusy), 128'(mOwner >= 0));
    if (eVld) begin
      checkVal("arb_pkt", 128'(oArb_pkt), 128'(ePkt));
      checkVal("arb_src", 128'(oArb_src), 128'(eSrc));
      checkVal("arb_sop", 128'(oArb_sop), 128'(eSop));
      checkVal("arb_eop", 128'(oArb_eop), 128'(eEop));
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkVal({tag, "_vld"},  128'(oArb_vld), 128'(0));
    checkVal({tag, "_pkt"},  128'(oArb_pkt), 128'(0));
    checkVal({tag, "_src"},  128'(oArb_src), 128'(0));
    checkVal({tag, "_sop"},  128'(oArb_sop), 128'(0));
    checkVal({tag, "_eop"},  128'(oArb_eop), 128'(0));
    checkVal({tag, "_ack"},  128'(oReq_ack), 128'(0));
    checkVal({tag, "_busy"}, 128'(oBusy),    128'(0));
  endtask

  task automatic stepCycle();
    #2;
    modelAck();
    checkVal("req_ack", 128'(oReq_ack), 128'(expAck));
    ackSeen  = oReq_ack;
    outDrain = oArb_vld && iArb_ack;
    @(posedge iClk);
    modelClock();
    cycleNo++;
    #1;
    if (outDrain) beatsOut++;
    checkOutput();
    if (oArb_vld && oArb_sop) begin
      srcLog.push_back(int'(oArb_src));
      cycLog.push_back(cycleNo);
    end
    applyStimulus(ackSeen);
  endtask

  function automatic bit allQuiet();
    bit q;
    q = (curVld == '0) && (mOwner < 0) && !eVld;
    for (int p = 0; p < NP; p++) begin
      if (bodyLeft[p] != 0 || pendRd[p] != pendCnt[p]) q = 1'b0;
    end
    return q;
  endfunction

  task automatic runUntilQuiet(input string tag, input int budget);
    int n;
    n = 0;
    while (!allQuiet() && n < budget) begin
      stepCycle();
      n++;
    end
    checkVal({tag, "_drained"},   128'(allQuiet()), 128'(1));
    checkVal({tag, "_beats_out"}, 128'(beatsOut),   128'(beatsQueued));
    checkVal({tag, "_beats_in"},  128'(beatsSent),  128'(beatsQueued));
  endtask

  // Asynchronous reset with random inputs applied; outputs must clear at once and stay clear
  task automatic doReset();
    #2;
    iRstn    = 1'b0;
    iReq_vld = NP'($urandom);
    for (int p = 0; p < NP; p++) iReq_pkt[p*PW +: PW] = randBeat();
    iArb_ack = 1'($urandom);
    #1;
    checkZeroOutputs("rst_async");
    repeat (2) @(posedge iClk);
    #1;
    checkZeroOutputs("rst_hold");
    clearRequesters();
    modelReset();
    srcLog.delete();
    cycLog.delete();
    cycleNo  = 0;
    iArb_ack = 1'b1;
    drivePins();
    iRstn = 1'b1;
  endtask

  initial begin
    logic [NP-1:0] mask;
    int            lowest;
    int            n;
    total    = 0;
    bad      = 0;
    iRstn    = 1'b0;
    iReq_vld = '0;
    iReq_pkt = '0;
    iArb_ack = 1'b0;
    ackMode  = 0;
    bubbleEn = 1'b0;
    clearRequesters();
    modelReset();

    // Reset, then the first grant goes to the lowest valid index
    doReset();
    mask = NP'($urandom) & 17'h0FFFF;
    if (mask == '0) mask = 17'h00100;
    lowest = -1;
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) begin
        queuePkt(p, int'($urandom_range(0, 3)));
        if (lowest < 0) lowest = p;
      end
    end
    applyStimulus('0);
    runUntilQuiet("t1", 600);
    checkVal("t1_log_nonempty", 128'(srcLog.size() > 0), 128'(1));
    checkVal("t1_first_src", 128'(srcLog.size() > 0 ? srcLog[0] : -1), 128'(lowest));
    checkVal("t1_pkt_count", 128'(srcLog.size()), 128'($countones(mask)));

    // Single packet on port 3, size 2, timing of grant/head/EOP/busy
    doReset();
    queuePkt(3, 2);
    applyStimulus('0);
    stepCycle();
    checkVal("t2_busy_after_grant", 128'(oBusy), 128'(1));
    checkVal("t2_no_beat_yet", 128'(oArb_vld), 128'(0));
    stepCycle();
    checkVal("t2_head_vld", 128'(oArb_vld), 128'(1));
    checkVal("t2_head_sop", 128'(oArb_sop), 128'(1));
    checkVal("t2_head_src", 128'(oArb_src), 128'(3));
    stepCycle();
    checkVal("t2_data1_eop", 128'(oArb_eop), 128'(0));
    stepCycle();
    checkVal("t2_last_eop", 128'(oArb_eop), 128'(1));
    checkVal("t2_busy_fall", 128'(oBusy), 128'(0));
    runUntilQuiet("t2", 20);

    // Round-robin among ports 2, 5, 9 with zero-size packets
    doReset();
    for (int r = 0; r < 2; r++) begin
      queuePkt(2, 0);
      queuePkt(5, 0);
      queuePkt(9, 0);
    end
    applyStimulus('0);
    runUntilQuiet("t3", 100);
    checkVal("t3_count", 128'(srcLog.size()), 128'(6));
    for (int i = 0; i < 6; i++) begin
      checkVal($sformatf("t3_order%0d", i), 128'(i < srcLog.size() ? srcLog[i] : -1), 128'(exp3[i]));
      if (i > 0 && i < cycLog.size())
        checkVal($sformatf("t3_gap%0d", i), 128'(cycLog[i] - cycLog[i-1]), 128'(2));
    end

    // Server priority: pointer parked at 5, server wins, pointer is not moved by the server
    doReset();
    queuePkt(4, 1);
    applyStimulus('0);
    runUntilQuiet("t4a", 40);
    srcLog.delete();
    queuePkt(16, 2);
    queuePkt(0, 1);
    queuePkt(6, 0);
    applyStimulus('0);
    runUntilQuiet("t4b", 80);
    checkVal("t4_count", 128'(srcLog.size()), 128'(3));
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("t4_order%0d", i), 128'(i < srcLog.size() ? srcLog[i] : -1), 128'(exp4[i]));
    end

    // Downstream stall of 5 cycles in the middle of a body
    doReset();
    ackMode  = 2;
    iArb_ack = 1'b1;
    queuePkt(7, 6);
    applyStimulus('0);
    n = 0;
    while (beatsSent < 3 && n < 40) begin
      stepCycle();
      n++;
    end
    iArb_ack = 1'b0;
    repeat (5) stepCycle();
    checkVal("t5_stall_vld", 128'(oArb_vld), 128'(1));
    checkVal("t5_stall_busy", 128'(oBusy), 128'(1));
    iArb_ack = 1'b1;
    runUntilQuiet("t5", 60);
    ackMode = 0;

    // Reset in the middle of a 256-beat packet, then random traffic
    doReset();
    queuePkt(1, 255);
    applyStimulus('0);
    n = 0;
    while (beatsSent < 10 && n < 60) begin
      stepCycle();
      n++;
    end
    checkVal("t6_busy_before", 128'(oBusy), 128'(1));
    checkVal("t6_vld_before", 128'(oArb_vld), 128'(1));
    doReset();
    ackMode  = 1;
    bubbleEn = 1'b1;
    for (int i = 0; i < 24; i++) begin
      queuePkt(int'($urandom_range(0, NP-1)), int'($urandom_range(0, 4)));
    end
    applyStimulus('0);
    runUntilQuiet("t6_rand", 3000);

    // A second random burst without a reset in between, server traffic included
    for (int i = 0; i < 16; i++) begin
      queuePkt((i % 4 == 0) ? NP-1 : int'($urandom_range(0, NP-2)), int'($urandom_range(0, 6)));
    end
    applyStimulus('0);
    runUntilQuiet("t7_rand", 3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
